// File: rtl/demux1_4_stream_pkg.sv
// Shared constants for the 1-to-4 stream demux and its per-channel holding registers.
package demux1_4_stream_pkg;
  localparam int CHAN_NUM = 4;
  localparam int SEL_W    = 2;
  localparam int CNT_W    = 8;
endpackage

// File: rtl/demux1_4_stream_chan_reg.sv
// One-entry channel holding register with full flag; load and drain may coincide without a bubble.
// Optional delivered-word counter compiled in with DEMUX_CNT_EN.
module demux_chan_reg
  import demux1_4_stream_pkg::*;
#(
  parameter int n = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [n-1:0]     dat_i,
  input  logic             rdy_i,
  output logic             vld_o,
`ifdef DEMUX_CNT_EN
  output logic [CNT_W-1:0] cnt_o,
`endif
  output logic [n-1:0]     dat_o
);

  logic         full_q, full_d;
  logic [n-1:0] data_q, data_d;
  logic         drain;

  assign drain = full_q & rdy_i;

  // A drain alone leaves the stale word in place; only a load rewrites it.
  always_comb begin
    full_d = load_i | (full_q & ~rdy_i);
    data_d = load_i ? dat_i : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign vld_o = full_q;
  assign dat_o = data_q;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drain) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`else
  logic unused_drain;
  assign unused_drain = drain;
`endif

endmodule

// File: rtl/demux1_4_stream.sv
// 1-to-4 valid/ready stream demux: one-cycle latency, full throughput per drained channel.
// Optional per-channel counters (cnt0..cnt3) compiled in with DEMUX_CNT_EN.
module demux1_4_stream
  import demux1_4_stream_pkg::*;
#(
  parameter int n = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic [n-1:0]        in_data,
  output logic [CHAN_NUM-1:0] out_valid,
  input  logic [CHAN_NUM-1:0] out_ready,
`ifdef DEMUX_CNT_EN
  output logic [CNT_W-1:0]    cnt0,
  output logic [CNT_W-1:0]    cnt1,
  output logic [CNT_W-1:0]    cnt2,
  output logic [CNT_W-1:0]    cnt3,
`endif
  output logic [n-1:0]        out_data0,
  output logic [n-1:0]        out_data1,
  output logic [n-1:0]        out_data2,
  output logic [n-1:0]        out_data3
);

  logic [CHAN_NUM-1:0] sel_dec;
  logic [CHAN_NUM-1:0] load;
  logic [n-1:0]        chan_dat [CHAN_NUM];
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0]    chan_cnt [CHAN_NUM];
`endif

  // Readiness looks only at the selected channel so a stalled neighbour never blocks.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];

  always_comb begin
    sel_dec = '0;
    sel_dec[in_sel] = 1'b1;
  end

  assign load = sel_dec & {CHAN_NUM{in_valid & in_ready}};

  for (genvar k = 0; k < CHAN_NUM; k++) begin : g_chan
    demux_chan_reg #(.n(n)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .load_i (load[k]),
      .dat_i  (in_data),
      .rdy_i  (out_ready[k]),
      .vld_o  (out_valid[k]),
`ifdef DEMUX_CNT_EN
      .cnt_o  (chan_cnt[k]),
`endif
      .dat_o  (chan_dat[k])
    );
  end

  assign out_data0 = chan_dat[0];
  assign out_data1 = chan_dat[1];
  assign out_data2 = chan_dat[2];
  assign out_data3 = chan_dat[3];

`ifdef DEMUX_CNT_EN
  assign cnt0 = chan_cnt[0];
  assign cnt1 = chan_cnt[1];
  assign cnt2 = chan_cnt[2];
  assign cnt3 = chan_cnt[3];
`endif

endmodule

// File: doc/demux1_4_stream.md
DEMUX1_4_STREAM -- requirements
Module: demux1_4_stream

Interface
REQ-001 Parameter: n, default 32, data word width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream word present.
REQ-005 Port: in_ready  output  1  demux accepts the word this cycle.
REQ-006 Port: in_sel  input  2  destination channel, 0..3.
REQ-007 Port: in_data  input  n  upstream word.
REQ-008 Port: out_valid  output  4  per-channel word present; bit k belongs to channel k.
REQ-009 Port: out_ready  input  4  per-channel downstream accept; bit k belongs to channel k.
REQ-010 Port: out_data0..out_data3  output  n each  per-channel held word.
REQ-011 Port: cnt0..cnt3  output  8 each  per-channel delivered-word count; present only with DEMUX_CNT_EN.

Function
REQ-012 The input handshake completes when in_valid && in_ready; the output handshake on channel k completes when out_valid[k] && out_ready[k].
REQ-013 Each channel holds one word in a one-entry register with a full flag that drives out_valid[k].
REQ-014 in_ready = !full[in_sel] || out_ready[in_sel], combinational; it depends on no other channel.
REQ-015 Latency: a word accepted in cycle t appears on out_data[in_sel] with out_valid high in cycle t+1.
REQ-016 Throughput: one word per cycle into any channel whose downstream holds out_ready high.
REQ-017 Empty channel + accept: load in_data and set full.
REQ-018 Full channel + drain with no accept: clear full; out_data keeps its stale value.
REQ-019 Full channel + drain + accept to the same channel in the same cycle: load the new word and keep full high, with no bubble.
REQ-020 Full channel with no drain: in_ready is low for that in_sel, and the register and out_data are unchanged.
REQ-021 out_data[k] and out_valid[k] are stable while out_valid[k] && !out_ready[k].
REQ-022 Channels other than in_sel are unaffected by the input handshake and drain independently in the same cycle.
REQ-023 in_sel and in_data are ignored when in_valid is low; no state changes.
REQ-024 Words to one channel exit in acceptance order; the block drops and duplicates nothing.

Reset
REQ-025 While rst is high: out_valid = 4'b0000, out_data0..3 = 0, counters = 0, and any held words are discarded.
REQ-026 in_ready during reset follows REQ-014 with all channels empty, so it equals 1.
REQ-027 Deassertion of rst mid-transfer leaves no partial state; the first accept after release behaves per REQ-017.

Configuration
REQ-028 Macro DEMUX_CNT_EN, when defined, compiles in cnt0..cnt3.
REQ-029 With DEMUX_CNT_EN, cnt[k] increments by 1 on each completed output handshake on channel k and wraps 255 -> 0.
REQ-030 Without DEMUX_CNT_EN, the ports and counter logic are absent and all other behaviour is identical.

Structure
REQ-031 A shared package holds the constants CHAN_NUM = 4, SEL_W = 2 and CNT_W = 8.
REQ-032 One sub-module, demux_chan_reg, is instantiated 4 times; it contains the one-entry register, the full flag, the load/drain logic and the optional counter.
REQ-033 The top level contains only the select decode and the in_ready mux.

Verification
REQ-034 Reset then in_valid=1, in_sel=2, in_data=0xA5A5A5A5, out_ready=4'b0000 -> in_ready=1; next cycle out_valid=4'b0100, out_data2=0xA5A5A5A5.
REQ-035 Channel 2 full, out_ready[2]=0, second word 0x11 to in_sel=2 -> in_ready=0, out_data2 holds 0xA5A5A5A5; set out_ready[2]=1 -> 0x11 accepted that cycle and appears next cycle, with out_valid[2] continuously high.
REQ-036 out_ready=4'b1111, words 1,2,3,4 on consecutive cycles to sel 0,1,2,3 -> each out_valid bit pulses for one cycle, one cycle after its accept, with in_ready constantly 1.
REQ-037 Channel 0 stalled full and a word sent to channel 3 -> in_ready=1 and channel 3 delivers while channel 0 is unchanged.
REQ-038 rst asserted asynchronously between clock edges while channels 1 and 3 are full -> out_valid=0 immediately; after release the next accept to channel 1 delivers only the new word.
REQ-039 With DEMUX_CNT_EN, 257 drains on channel 0 -> cnt0=1 and cnt1..cnt3=0.
